// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operation sequencer.
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, FLAGS, RESP} seq_state_e;
  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_CS = 3'd3;
  localparam logic [2:0] COND_CC = 3'd4;
  localparam logic [2:0] COND_MI = 3'd5;
  localparam logic [2:0] COND_VS = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_O = 3;
  localparam logic [4:0] FUNSEL_ADD32 = 5'b10100;
  localparam logic [4:0] FUNSEL_LSL32 = 5'b11011;
  function automatic logic [4:0] eff_count(input logic [4:0] c);
    return c == 5'd0 ? 5'd1 : c;
  endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, ALU and response signals of the sequencer.
interface alu_op_sequencer_if;
  logic        CmdValid;
  logic        CmdReady;
  logic [4:0]  CmdOp;
  logic [4:0]  CmdCount;
  logic        CmdSetFlags;
  logic [2:0]  CmdCond;
  logic [31:0] CmdA;
  logic [31:0] CmdB;
  logic [4:0]  FunSel;
  logic        WF;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [31:0] AluResult;
  logic [3:0]  FlagsIn;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspResult;
  logic [3:0]  RspFlags;
  logic        RspCondMet;
  modport master (
    input  CmdValid, CmdOp, CmdCount, CmdSetFlags, CmdCond, CmdA, CmdB,
    input  AluResult, FlagsIn, RspReady,
    output CmdReady, FunSel, WF, AluA, AluB,
    output RspValid, RspResult, RspFlags, RspCondMet
  );
  modport slave (
    output CmdValid, CmdOp, CmdCount, CmdSetFlags, CmdCond, CmdA, CmdB,
    output AluResult, FlagsIn, RspReady,
    input  CmdReady, FunSel, WF, AluA, AluB,
    input  RspValid, RspResult, RspFlags, RspCondMet
  );
endinterface

// File: rtl/alu_cond_eval.sv
// alu_cond_eval: evaluates a 3-bit condition code against the Z/C/N/O flags.
module alu_cond_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondMet
);
  always_comb begin
    CondMet = 1'b0;
    case (Cond)
      COND_AL: CondMet = 1'b1;
      COND_EQ: CondMet = Flags[FLAG_Z];
      COND_NE: CondMet = !Flags[FLAG_Z];
      COND_CS: CondMet = Flags[FLAG_C];
      COND_CC: CondMet = !Flags[FLAG_C];
      COND_MI: CondMet = Flags[FLAG_N];
      COND_VS: CondMet = Flags[FLAG_O];
      COND_NV: CondMet = 1'b0;
      default: CondMet = 1'b0;
    endcase
  end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues one ALU operation per command, repeating it with the
// result fed back into A, then returns result, registered flags and condition.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic Clock,
  input  logic Reset,
  alu_op_sequencer_if.master bus
);
  seq_state_e  state, state_nx;
  logic [4:0]  op, cnt;
  logic [2:0]  cond;
  logic [31:0] a, b, acc;
  logic [3:0]  flags;
  logic        set_flags, first, accept, issuing, rsp, cond_met;
  assign accept  = bus.CmdValid && bus.CmdReady;
  assign issuing = state == ISSUE;
  assign rsp     = state == RESP;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = cnt == 5'd1 ? FLAGS : ISSUE;
      FLAGS:   state_nx = RESP;
      RESP:    state_nx = bus.RspReady ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  // Flags are sampled in FLAGS because the ALU clears them once WF drops.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      op        <= '0;
      cnt       <= '0;
      cond      <= '0;
      a         <= '0;
      b         <= '0;
      acc       <= '0;
      flags     <= '0;
      set_flags <= 1'b0;
      first     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op        <= bus.CmdOp;
        cnt       <= eff_count(bus.CmdCount);
        set_flags <= bus.CmdSetFlags;
        cond      <= bus.CmdCond;
        a         <= bus.CmdA;
        b         <= bus.CmdB;
        first     <= 1'b1;
      end
      if (issuing) begin
        acc   <= bus.AluResult;
        cnt   <= cnt - 5'd1;
        first <= 1'b0;
      end
      if (state == FLAGS && set_flags) flags <= bus.FlagsIn;
    end
  end
  alu_cond_eval u_cond (.Cond(cond), .Flags(flags), .CondMet(cond_met));
  assign bus.CmdReady   = Reset && state == IDLE;
  assign bus.FunSel     = issuing ? op : '0;
  assign bus.WF         = issuing && set_flags;
  assign bus.AluA       = issuing ? (first ? a : acc) : '0;
  assign bus.AluB       = issuing ? b : '0;
  assign bus.RspValid   = rsp;
  assign bus.RspResult  = rsp ? acc : '0;
  assign bus.RspFlags   = rsp ? flags : '0;
  assign bus.RspCondMet = rsp && cond_met;
endmodule
